// File: rtl/console_pkg.sv
// Shared types, ASCII constants and address packing for the text console write path.
package console_pkg;

    localparam int unsigned COLS_DEF   = 80;
    localparam int unsigned ROWS_DEF   = 30;
    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned ROW_W      = 5;
    localparam int unsigned COL_W      = 7;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned PACK_W     = ROW_W + COL_W;

    localparam logic [DATA_W-1:0] ASCII_BS       = 8'h08;
    localparam logic [DATA_W-1:0] ASCII_LF       = 8'h0A;
    localparam logic [DATA_W-1:0] ASCII_FF       = 8'h0C;
    localparam logic [DATA_W-1:0] ASCII_CR       = 8'h0D;
    localparam logic [DATA_W-1:0] ASCII_SPACE    = 8'h20;
    localparam logic [DATA_W-1:0] ASCII_PRINT_LO = 8'h20;
    localparam logic [DATA_W-1:0] ASCII_PRINT_HI = 8'h7E;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        CUR_NONE    = 3'd0,
        CUR_ADVANCE = 3'd1,
        CUR_NEWLINE = 3'd2,
        CUR_RETURN  = 3'd3,
        CUR_BACK    = 3'd4,
        CUR_HOME    = 3'd5
    } cur_cmd_t;

    // One screen RAM write: packed {row, col} address plus character.
    typedef struct packed {
        logic [PACK_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ram_wr_t;

    function automatic logic [PACK_W-1:0] pack_addr(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/text_cursor.sv
// Cursor row/column register with advance, newline, return, backspace and home.
module text_cursor
    import console_pkg::*;
#(
    parameter int unsigned COLS = COLS_DEF,
    parameter int unsigned ROWS = ROWS_DEF
) (
    input  logic             clk25,
    input  logic             rst_n,
    input  cur_cmd_t         i_cmd,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col
);

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] w_row_nxt;
    logic [COL_W-1:0] w_col_nxt;
    logic [ROW_W-1:0] w_row_down;
    logic             w_last_col;

    assign w_last_col = (r_col == COL_W'(COLS - 1));
    assign w_row_down = (r_row == ROW_W'(ROWS - 1)) ? '0 : r_row + ROW_W'(1);

    // Next cursor position; the screen wraps to row 0 rather than scrolling.
    always_comb begin
        w_row_nxt = r_row;
        w_col_nxt = r_col;
        case (i_cmd)
            CUR_ADVANCE: begin
                if (w_last_col) begin
                    w_col_nxt = '0;
                    w_row_nxt = w_row_down;
                end else begin
                    w_col_nxt = r_col + COL_W'(1);
                end
            end
            CUR_NEWLINE: begin
                w_col_nxt = '0;
                w_row_nxt = w_row_down;
            end
            CUR_RETURN: w_col_nxt = '0;
            CUR_BACK: begin
                if (r_col != '0) begin
                    w_col_nxt = r_col - COL_W'(1);
                end else if (r_row != '0) begin
                    w_row_nxt = r_row - ROW_W'(1);
                    w_col_nxt = COL_W'(COLS - 1);
                end
            end
            CUR_HOME: begin
                w_row_nxt = '0;
                w_col_nxt = '0;
            end
            default: ;
        endcase
    end

    // Cursor state register.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else begin
            r_row <= w_row_nxt;
            r_col <= w_col_nxt;
        end
    end

    assign o_row = r_row;
    assign o_col = r_col;

endmodule

// File: rtl/text_console_writer.sv
// Byte-stream to screen RAM writer: control-code decode, cursor, full-screen clear.
// Optional macro CONSOLE_CLEAR_ON_RESET_EN: leave reset into a full-screen clear.
// COLS is assumed to be at least 2.
module text_console_writer
    import console_pkg::*;
#(
    parameter int unsigned COLS   = COLS_DEF,
    parameter int unsigned ROWS   = ROWS_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk25,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic [ROW_W-1:0]  cur_row,
    output logic [COL_W-1:0]  cur_col,
    output logic              busy
);

`ifdef CONSOLE_CLEAR_ON_RESET_EN
    localparam state_t ST_RESET = ST_CLEAR;
`else
    localparam state_t ST_RESET = ST_IDLE;
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_we;
    logic             w_we_nxt;
    ram_wr_t          r_wr;
    ram_wr_t          w_wr_nxt;
    logic [ROW_W-1:0] r_clr_row;
    logic [ROW_W-1:0] w_clr_row_nxt;
    logic [COL_W-1:0] r_clr_col;
    logic [COL_W-1:0] w_clr_col_nxt;
    logic             r_clr_last;
    logic             w_clr_last_nxt;
    cur_cmd_t         w_cmd;
    logic [ROW_W-1:0] w_row;
    logic [COL_W-1:0] w_col;
    logic             w_accept;
    logic             w_printable;

    text_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk25 (clk25),
        .rst_n (rst_n),
        .i_cmd (w_cmd),
        .o_row (w_row),
        .o_col (w_col)
    );

    assign in_ready    = (r_state == ST_IDLE) && rst_n;
    assign busy        = (r_state == ST_CLEAR) && rst_n;
    assign w_accept    = in_valid && in_ready;
    assign w_printable = (in_data >= ASCII_PRINT_LO) && (in_data <= ASCII_PRINT_HI);

    // Decode accepted bytes in IDLE; walk the visible area row-major in CLEAR.
    always_comb begin
        w_state_nxt    = r_state;
        w_we_nxt       = 1'b0;
        w_wr_nxt       = r_wr;
        w_clr_row_nxt  = r_clr_row;
        w_clr_col_nxt  = r_clr_col;
        w_clr_last_nxt = r_clr_last;
        w_cmd          = CUR_NONE;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_printable) begin
                        w_we_nxt      = 1'b1;
                        w_wr_nxt.addr = pack_addr(w_row, w_col);
                        w_wr_nxt.data = in_data;
                        w_cmd         = CUR_ADVANCE;
                    end else begin
                        case (in_data)
                            ASCII_LF: w_cmd = CUR_NEWLINE;
                            ASCII_CR: w_cmd = CUR_RETURN;
                            ASCII_BS: begin
                                // Erase lands on the new cursor cell; no-op at home.
                                if (w_col != '0) begin
                                    w_we_nxt      = 1'b1;
                                    w_wr_nxt.addr = pack_addr(w_row, w_col - COL_W'(1));
                                    w_wr_nxt.data = ASCII_SPACE;
                                    w_cmd         = CUR_BACK;
                                end else if (w_row != '0) begin
                                    w_we_nxt      = 1'b1;
                                    w_wr_nxt.addr = pack_addr(w_row - ROW_W'(1),
                                                              COL_W'(COLS - 1));
                                    w_wr_nxt.data = ASCII_SPACE;
                                    w_cmd         = CUR_BACK;
                                end
                            end
                            ASCII_FF: begin
                                // First blank goes out on the accept edge itself.
                                w_state_nxt    = ST_CLEAR;
                                w_we_nxt       = 1'b1;
                                w_wr_nxt.addr  = '0;
                                w_wr_nxt.data  = ASCII_SPACE;
                                w_clr_row_nxt  = '0;
                                w_clr_col_nxt  = COL_W'(1);
                                w_clr_last_nxt = 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_CLEAR: begin
                if (r_clr_last) begin
                    w_state_nxt    = ST_IDLE;
                    w_clr_row_nxt  = '0;
                    w_clr_col_nxt  = '0;
                    w_clr_last_nxt = 1'b0;
                end else begin
                    w_we_nxt      = 1'b1;
                    w_wr_nxt.addr = pack_addr(r_clr_row, r_clr_col);
                    w_wr_nxt.data = ASCII_SPACE;
                    if (r_clr_col == COL_W'(COLS - 1)) begin
                        w_clr_col_nxt = '0;
                        if (r_clr_row == ROW_W'(ROWS - 1)) begin
                            w_clr_last_nxt = 1'b1;
                            w_cmd          = CUR_HOME;
                        end else begin
                            w_clr_row_nxt = r_clr_row + ROW_W'(1);
                        end
                    end else begin
                        w_clr_col_nxt = r_clr_col + COL_W'(1);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM, clear walker and registered RAM write port.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RESET;
            r_we       <= 1'b0;
            r_wr       <= '0;
            r_clr_row  <= '0;
            r_clr_col  <= '0;
            r_clr_last <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_we       <= w_we_nxt;
            r_wr       <= w_wr_nxt;
            r_clr_row  <= w_clr_row_nxt;
            r_clr_col  <= w_clr_col_nxt;
            r_clr_last <= w_clr_last_nxt;
        end
    end

    assign ram_we   = r_we;
    assign ram_addr = ADDR_W'(r_wr.addr);
    assign ram_data = r_wr.data;
    assign cur_row  = w_row;
    assign cur_col  = w_col;

endmodule
